// File: rtl/regfile_pkg.sv
// Shared definitions for the MIPS register-file write-back path.
// Used by regwrite_queue, regwrite_arb and the write-back queue testbench.
package regfile_pkg;

    localparam int REG_AW   = 5;
    localparam int REG_W    = 32;
    localparam int REG_ZERO = 0;

    typedef struct packed {
        logic [REG_AW-1:0] wreg;
        logic [REG_W-1:0]  data;
    } wr_req_t;

endpackage

// File: rtl/regwrite_queue_if.sv
// Handshake/bus bundle of the write-back queue. Optional macro REGWRITE_QUEUE_BYPASS_EN
// adds the PendingData1/PendingData2 forwarding outputs.
interface regwrite_queue_if #(
    parameter int DEPTH = 4,
    parameter int WIDTH = regfile_pkg::REG_W,
    parameter int AW    = regfile_pkg::REG_AW
);

    logic                     AluValid;
    logic                     AluReady;
    logic [AW-1:0]            AluReg;
    logic [WIDTH-1:0]         AluData;
    logic                     MemValid;
    logic                     MemReady;
    logic [AW-1:0]            MemReg;
    logic [WIDTH-1:0]         MemData;
    logic                     DrainEn;
    logic [WIDTH-1:0]         WriteData;
    logic [AW-1:0]            WriteRegister;
    logic                     RegWrite;
    logic [AW-1:0]            QueryReg1;
    logic [AW-1:0]            QueryReg2;
    logic                     Pending1;
    logic                     Pending2;
    logic [$clog2(DEPTH):0]   Count;
    logic                     Full;
    logic                     Empty;
`ifdef REGWRITE_QUEUE_BYPASS_EN
    logic [WIDTH-1:0]         PendingData1;
    logic [WIDTH-1:0]         PendingData2;
`endif

    // Queue side: consumes requests and queries, drives the register-file write port.
    modport slave (
        input  AluValid, AluReg, AluData, MemValid, MemReg, MemData,
        input  DrainEn, QueryReg1, QueryReg2,
        output AluReady, MemReady, WriteData, WriteRegister, RegWrite,
        output Pending1, Pending2, Count, Full, Empty
`ifdef REGWRITE_QUEUE_BYPASS_EN
        , output PendingData1, PendingData2
`endif
    );

    modport master (
        output AluValid, AluReg, AluData, MemValid, MemReg, MemData,
        output DrainEn, QueryReg1, QueryReg2,
        input  AluReady, MemReady, WriteData, WriteRegister, RegWrite,
        input  Pending1, Pending2, Count, Full, Empty
`ifdef REGWRITE_QUEUE_BYPASS_EN
        , input PendingData1, PendingData2
`endif
    );

endinterface

// File: rtl/regwrite_arb.sv
// Two-source round-robin arbiter (ALU vs load unit) for the write-back queue.
// PrefMem decides ties and flips after every contested grant.
module regwrite_arb
    import regfile_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic alu_valid,
    input  logic mem_valid,
    input  logic accept_ok,
    output logic alu_grant,
    output logic mem_grant,
    output logic any_grant
);

    logic pref_mem_q;
    logic pref_mem_d;

    always_comb begin
        alu_grant  = 1'b0;
        mem_grant  = 1'b0;
        pref_mem_d = pref_mem_q;
        if (accept_ok) begin
            if (alu_valid && mem_valid) begin
                mem_grant  = pref_mem_q;
                alu_grant  = !pref_mem_q;
                pref_mem_d = !pref_mem_q;
            end else if (mem_valid) begin
                mem_grant = 1'b1;
            end else if (alu_valid) begin
                alu_grant = 1'b1;
            end
        end
        any_grant = alu_grant || mem_grant;
    end

    // The load unit wins the first contested cycle after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pref_mem_q <= 1'b1;
        end else begin
            pref_mem_q <= pref_mem_d;
        end
    end

endmodule

// File: rtl/regwrite_queue.sv
// Write-back queue in front of the 32x32 MIPS register file: arbitrates ALU/load requests,
// buffers them in a FIFO and reports pending writes. Optional macro REGWRITE_QUEUE_BYPASS_EN.
module regwrite_queue
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = REG_W,
    parameter int AW    = REG_AW
) (
    input  logic            Clk,
    input  logic            Reset,
    regwrite_queue_if.slave bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0]    reg_q  [DEPTH];
    logic [AW-1:0]    reg_d  [DEPTH];
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;

    logic             alu_grant;
    logic             mem_grant;
    logic             any_grant;
    logic [AW-1:0]    in_reg;
    logic [WIDTH-1:0] in_data;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    logic             pend1;
    logic             pend2;
    logic [PW-1:0]    scan_idx;
`ifdef REGWRITE_QUEUE_BYPASS_EN
    logic [WIDTH-1:0] pdata1;
    logic [WIDTH-1:0] pdata2;
`endif

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    regwrite_arb u_arb (
        .clk       (Clk),
        .rst       (Reset),
        .alu_valid (bus.AluValid),
        .mem_valid (bus.MemValid),
        .accept_ok (!full),
        .alu_grant (alu_grant),
        .mem_grant (mem_grant),
        .any_grant (any_grant)
    );

    // Writes to r0 are acknowledged but dropped; the register file would ignore them anyway.
    assign in_reg  = mem_grant ? bus.MemReg  : bus.AluReg;
    assign in_data = mem_grant ? bus.MemData : bus.AluData;
    assign push    = any_grant && (in_reg != AW'(REG_ZERO));
    assign pop     = !empty && bus.DrainEn;

    always_comb begin
        reg_d   = reg_q;
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) begin
            reg_d[tail_q]  = in_reg;
            data_d[tail_q] = in_data;
            tail_d         = tail_q + PW'(1);
        end
        if (pop) begin
            head_d = head_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                reg_q[i]  <= '0;
                data_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            reg_q   <= reg_d;
            data_q  <= data_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Scan oldest to youngest so the last hit is the youngest matching entry.
    always_comb begin
        pend1    = 1'b0;
        pend2    = 1'b0;
        scan_idx = '0;
`ifdef REGWRITE_QUEUE_BYPASS_EN
        pdata1   = '0;
        pdata2   = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = head_q + PW'(k);
            if (CW'(k) < count_q) begin
                if ((reg_q[scan_idx] == bus.QueryReg1) && (bus.QueryReg1 != AW'(REG_ZERO))) begin
                    pend1 = 1'b1;
`ifdef REGWRITE_QUEUE_BYPASS_EN
                    pdata1 = data_q[scan_idx];
`endif
                end
                if ((reg_q[scan_idx] == bus.QueryReg2) && (bus.QueryReg2 != AW'(REG_ZERO))) begin
                    pend2 = 1'b1;
`ifdef REGWRITE_QUEUE_BYPASS_EN
                    pdata2 = data_q[scan_idx];
`endif
                end
            end
        end
    end

    assign bus.AluReady      = alu_grant;
    assign bus.MemReady      = mem_grant;
    assign bus.RegWrite      = pop;
    assign bus.WriteData     = empty ? '0 : data_q[head_q];
    assign bus.WriteRegister = empty ? '0 : reg_q[head_q];
    assign bus.Pending1      = pend1;
    assign bus.Pending2      = pend2;
    assign bus.Count         = count_q;
    assign bus.Full          = full;
    assign bus.Empty         = empty;
`ifdef REGWRITE_QUEUE_BYPASS_EN
    assign bus.PendingData1  = pdata1;
    assign bus.PendingData2  = pdata2;
`endif

endmodule

// File: tb/tb_regwrite_queue.sv
// Directed testbench for regwrite_queue; also exercises PendingData1/2 when
// REGWRITE_QUEUE_BYPASS_EN is defined.
module tb_regwrite_queue
    import regfile_pkg::*;
;

    logic Clk = 1'b0;
    logic Reset = 1'b0;
    int   tests_run = 0;
    int   tests_failed = 0;

    logic [31:0] rf [32];
    int          zero_writes = 0;

    regwrite_queue_if #(.DEPTH(4), .WIDTH(32), .AW(5)) bus ();

    regwrite_queue #(.DEPTH(4), .WIDTH(32), .AW(5)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    // Behavioural register file sitting on the write port.
    always @(posedge Clk) begin
        if (bus.RegWrite) begin
            if (bus.WriteRegister == 5'd0) zero_writes++;
            else rf[bus.WriteRegister] <= bus.WriteData;
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.AluValid = 1'b0; bus.AluReg = '0; bus.AluData = '0;
        bus.MemValid = 1'b0; bus.MemReg = '0; bus.MemData = '0;
        bus.DrainEn = 1'b0; bus.QueryReg1 = '0; bus.QueryReg2 = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.QueryReg1 = 5'd5; bus.QueryReg2 = 5'd9; bus.DrainEn = 1'b1;
        Reset = 1'b1;
        tick();
        tick();
        tests_run++; if (bus.Empty !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_empty: got %0b, expected 1", bus.Empty); end
        tests_run++; if (bus.Full !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_full: got %0b, expected 0", bus.Full); end
        tests_run++; if (bus.RegWrite !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_regwrite: got %0b, expected 0", bus.RegWrite); end
        tests_run++; if (bus.WriteData !== 32'd0) begin tests_failed++; $display("[TB] FAIL reset_wdata: got %0h, expected 0", bus.WriteData); end
        tests_run++; if (bus.WriteRegister !== 5'd0) begin tests_failed++; $display("[TB] FAIL reset_wreg: got %0d, expected 0", bus.WriteRegister); end
        tests_run++; if ({bus.Pending1, bus.Pending2} !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_pending: got %b, expected 00", {bus.Pending1, bus.Pending2}); end
        tests_run++; if (bus.Count !== 3'd0) begin tests_failed++; $display("[TB] FAIL reset_count: got %0d, expected 0", bus.Count); end
        Reset = 1'b0;
        idle_inputs();
    endtask

    task automatic test_single_alu();
        apply_reset();
        bus.AluValid = 1'b1; bus.AluReg = 5'd5; bus.AluData = 32'hDEADBEEF; bus.DrainEn = 1'b1;
        #1;
        tests_run++; if (bus.AluReady !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_aluready: got %0b, expected 1", bus.AluReady); end
        tick();
        bus.AluValid = 1'b0;
        #1;
        tests_run++; if (bus.RegWrite !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_regwrite: got %0b, expected 1", bus.RegWrite); end
        tests_run++; if (bus.WriteRegister !== 5'd5) begin tests_failed++; $display("[TB] FAIL single_wreg: got %0d, expected 5", bus.WriteRegister); end
        tests_run++; if (bus.WriteData !== 32'hDEADBEEF) begin tests_failed++; $display("[TB] FAIL single_wdata: got %0h, expected deadbeef", bus.WriteData); end
        tick();
        tests_run++; if (bus.Empty !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_empty: got %0b, expected 1", bus.Empty); end
        tests_run++; if (rf[5] !== 32'hDEADBEEF) begin tests_failed++; $display("[TB] FAIL single_rf5: got %0h, expected deadbeef", rf[5]); end
    endtask

    task automatic test_arbitration();
        int ai = 0;
        int mi = 0;
        wr_req_t exp_order [4];
        apply_reset();
        exp_order[0] = '{wreg: 5'd11, data: 32'hB000_000B};
        exp_order[1] = '{wreg: 5'd1,  data: 32'hA000_0001};
        exp_order[2] = '{wreg: 5'd12, data: 32'hB000_000C};
        exp_order[3] = '{wreg: 5'd2,  data: 32'hA000_0002};
        for (int c = 0; c < 4; c++) begin
            logic exp_mem;
            bus.AluValid = 1'b1; bus.AluReg = 5'(1 + ai);  bus.AluData = 32'hA000_0000 + 32'(1 + ai);
            bus.MemValid = 1'b1; bus.MemReg = 5'(11 + mi); bus.MemData = 32'hB000_0000 + 32'(11 + mi);
            exp_mem = (c % 2 == 0);
            #1;
            tests_run++; if (bus.MemReady !== exp_mem) begin tests_failed++; $display("[TB] FAIL arb_memready_c%0d: got %0b, expected %0b", c, bus.MemReady, exp_mem); end
            tests_run++; if (bus.AluReady !== !exp_mem) begin tests_failed++; $display("[TB] FAIL arb_aluready_c%0d: got %0b, expected %0b", c, bus.AluReady, !exp_mem); end
            tick();
            if (exp_mem) mi++; else ai++;
        end
        bus.AluReg = 5'(1 + ai); bus.MemReg = 5'(11 + mi);
        #1;
        tests_run++; if (bus.Full !== 1'b1) begin tests_failed++; $display("[TB] FAIL arb_full: got %0b, expected 1", bus.Full); end
        tests_run++; if ({bus.AluReady, bus.MemReady} !== 2'b00) begin tests_failed++; $display("[TB] FAIL arb_ready_when_full: got %b, expected 00", {bus.AluReady, bus.MemReady}); end
        tests_run++; if (bus.Count !== 3'd4) begin tests_failed++; $display("[TB] FAIL arb_count: got %0d, expected 4", bus.Count); end
        tick();
        bus.AluValid = 1'b0; bus.MemValid = 1'b0; bus.DrainEn = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            tests_run++; if (bus.WriteRegister !== exp_order[i].wreg) begin tests_failed++; $display("[TB] FAIL arb_drain_reg%0d: got %0d, expected %0d", i, bus.WriteRegister, exp_order[i].wreg); end
            tests_run++; if (bus.WriteData !== exp_order[i].data) begin tests_failed++; $display("[TB] FAIL arb_drain_data%0d: got %0h, expected %0h", i, bus.WriteData, exp_order[i].data); end
            tick();
        end
        tests_run++; if (bus.Empty !== 1'b1) begin tests_failed++; $display("[TB] FAIL arb_drained_empty: got %0b, expected 1", bus.Empty); end
    endtask

    task automatic test_full_pop();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            bus.AluValid = 1'b1; bus.AluReg = 5'(21 + i); bus.AluData = 32'h100 + 32'(i);
            tick();
        end
        bus.AluReg = 5'd25; bus.AluData = 32'h125; bus.DrainEn = 1'b1;
        #1;
        tests_run++; if (bus.AluReady !== 1'b0) begin tests_failed++; $display("[TB] FAIL full_pop_noready: got %0b, expected 0", bus.AluReady); end
        tests_run++; if (bus.WriteRegister !== 5'd21) begin tests_failed++; $display("[TB] FAIL full_pop_head: got %0d, expected 21", bus.WriteRegister); end
        tick();
        bus.DrainEn = 1'b0;
        #1;
        tests_run++; if (bus.Count !== 3'd3) begin tests_failed++; $display("[TB] FAIL full_pop_count3: got %0d, expected 3", bus.Count); end
        tests_run++; if (bus.AluReady !== 1'b1) begin tests_failed++; $display("[TB] FAIL full_pop_retry_ready: got %0b, expected 1", bus.AluReady); end
        tick();
        bus.AluValid = 1'b0; bus.DrainEn = 1'b1;
        #1;
        tests_run++; if (bus.Count !== 3'd4) begin tests_failed++; $display("[TB] FAIL full_pop_count4: got %0d, expected 4", bus.Count); end
        for (int i = 0; i < 4; i++) begin
            tests_run++; if (bus.WriteRegister !== 5'(22 + i)) begin tests_failed++; $display("[TB] FAIL full_pop_order%0d: got %0d, expected %0d", i, bus.WriteRegister, 22 + i); end
            tick();
        end
        tests_run++; if (rf[25] !== 32'h125) begin tests_failed++; $display("[TB] FAIL full_pop_wrap_data: got %0h, expected 125", rf[25]); end
    endtask

    task automatic test_reg_zero();
        int zw0;
        apply_reset();
        zw0 = zero_writes;
        bus.AluValid = 1'b1; bus.AluReg = 5'd0; bus.AluData = 32'h1234; bus.DrainEn = 1'b1;
        #1;
        tests_run++; if (bus.AluReady !== 1'b1) begin tests_failed++; $display("[TB] FAIL zero_ready: got %0b, expected 1", bus.AluReady); end
        tick();
        bus.AluValid = 1'b0;
        #1;
        tests_run++; if (bus.Count !== 3'd0) begin tests_failed++; $display("[TB] FAIL zero_count: got %0d, expected 0", bus.Count); end
        tests_run++; if (bus.RegWrite !== 1'b0) begin tests_failed++; $display("[TB] FAIL zero_regwrite: got %0b, expected 0", bus.RegWrite); end
        tick();
        tests_run++; if (zero_writes !== zw0) begin tests_failed++; $display("[TB] FAIL zero_rf_writes: got %0d, expected %0d", zero_writes, zw0); end
    endtask

    task automatic test_pending();
        apply_reset();
        bus.QueryReg1 = 5'd9; bus.QueryReg2 = 5'd8;
        bus.AluValid = 1'b1; bus.AluReg = 5'd7; bus.AluData = 32'h77;
        tick();
        bus.AluReg = 5'd9; bus.AluData = 32'hA;
        #1;
        tests_run++; if (bus.Pending1 !== 1'b0) begin tests_failed++; $display("[TB] FAIL pend_not_yet_visible: got %0b, expected 0", bus.Pending1); end
        tick();
        bus.AluValid = 1'b0;
        #1;
        tests_run++; if (bus.Pending1 !== 1'b1) begin tests_failed++; $display("[TB] FAIL pend_q9: got %0b, expected 1", bus.Pending1); end
        tests_run++; if (bus.Pending2 !== 1'b0) begin tests_failed++; $display("[TB] FAIL pend_q8: got %0b, expected 0", bus.Pending2); end
        bus.QueryReg2 = 5'd7;
        #1;
        tests_run++; if (bus.Pending2 !== 1'b1) begin tests_failed++; $display("[TB] FAIL pend_head_q7: got %0b, expected 1", bus.Pending2); end
`ifdef REGWRITE_QUEUE_BYPASS_EN
        bus.AluValid = 1'b1; bus.AluReg = 5'd9; bus.AluData = 32'hB;
        tick();
        bus.AluValid = 1'b0; bus.QueryReg2 = 5'd8;
        #1;
        tests_run++; if (bus.PendingData1 !== 32'hB) begin tests_failed++; $display("[TB] FAIL bypass_youngest: got %0h, expected b", bus.PendingData1); end
        tests_run++; if (bus.PendingData2 !== 32'h0) begin tests_failed++; $display("[TB] FAIL bypass_nomatch: got %0h, expected 0", bus.PendingData2); end
        bus.QueryReg2 = 5'd7;
`endif
        bus.DrainEn = 1'b1;
        tick();
        tests_run++; if (bus.Pending2 !== 1'b0) begin tests_failed++; $display("[TB] FAIL pend_popped_q7: got %0b, expected 0", bus.Pending2); end
        tests_run++; if (bus.Pending1 !== 1'b1) begin tests_failed++; $display("[TB] FAIL pend_q9_after_pop: got %0b, expected 1", bus.Pending1); end
        tick();
        tick();
        tests_run++; if (bus.Pending1 !== 1'b0) begin tests_failed++; $display("[TB] FAIL pend_q9_drained: got %0b, expected 0", bus.Pending1); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        bus.DrainEn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.MemValid = 1'b1; bus.MemReg = 5'(16 + i); bus.MemData = 32'hC0 + 32'(i);
            #1;
            tests_run++; if (bus.MemReady !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_ready%0d: got %0b, expected 1", i, bus.MemReady); end
            if (i > 0) begin
                tests_run++; if (bus.WriteRegister !== 5'(15 + i)) begin tests_failed++; $display("[TB] FAIL b2b_wreg%0d: got %0d, expected %0d", i, bus.WriteRegister, 15 + i); end
                tests_run++; if (bus.Count !== 3'd1) begin tests_failed++; $display("[TB] FAIL b2b_count%0d: got %0d, expected 1", i, bus.Count); end
            end
            tick();
        end
        bus.MemValid = 1'b0;
        #1;
        tests_run++; if (bus.WriteRegister !== 5'd19) begin tests_failed++; $display("[TB] FAIL b2b_last: got %0d, expected 19", bus.WriteRegister); end
        tick();
        tests_run++; if (rf[18] !== 32'hC2) begin tests_failed++; $display("[TB] FAIL b2b_rf18: got %0h, expected c2", rf[18]); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            bus.AluValid = 1'b1; bus.AluReg = 5'(3 + i); bus.AluData = 32'h300 + 32'(i);
            tick();
        end
        bus.AluValid = 1'b0; bus.DrainEn = 1'b1;
        #1;
        tests_run++; if (bus.RegWrite !== 1'b1) begin tests_failed++; $display("[TB] FAIL midreset_pre_regwrite: got %0b, expected 1", bus.RegWrite); end
        tests_run++; if (bus.Count !== 3'd3) begin tests_failed++; $display("[TB] FAIL midreset_pre_count: got %0d, expected 3", bus.Count); end
        #2 Reset = 1'b1;
        #1;
        tests_run++; if (bus.RegWrite !== 1'b0) begin tests_failed++; $display("[TB] FAIL midreset_regwrite: got %0b, expected 0", bus.RegWrite); end
        tests_run++; if (bus.Count !== 3'd0) begin tests_failed++; $display("[TB] FAIL midreset_count: got %0d, expected 0", bus.Count); end
        tests_run++; if (bus.WriteData !== 32'd0) begin tests_failed++; $display("[TB] FAIL midreset_wdata: got %0h, expected 0", bus.WriteData); end
        tick();
        Reset = 1'b0;
        tick();
        tests_run++; if (bus.Empty !== 1'b1) begin tests_failed++; $display("[TB] FAIL midreset_stays_empty: got %0b, expected 1", bus.Empty); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_alu();
        test_arbitration();
        test_full_pop();
        test_reg_zero();
        test_pending();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete within 200000 time units");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/regwrite_queue.md
Name: regwrite_queue

Overview:
- Write-back queue sitting directly upstream of the 32x32 MIPS register file.
- Accepts write-back requests from two producers, the ALU and the load unit, through valid/ready handshakes.
- Arbitrates between them, buffers the requests in a small FIFO, and drains one entry per cycle onto the register file write port (WriteData / WriteRegister / RegWrite).
- Reports whether a queried register still has a pending write, so decode can stall on the hazard.

Parameters:
- DEPTH, 4: number of FIFO entries; must be a power of 2, minimum 2.
- WIDTH, 32: data width in bits.
- AW, 5: register address width in bits.

Ports:
- Clk  in  1  clock; all state updates on the positive edge.
- Reset  in  1  asynchronous reset, active-high.
- AluValid  in  1  ALU request valid.
- AluReady  out  1  ALU request accepted this cycle.
- AluReg  in  AW  ALU destination register.
- AluData  in  WIDTH  ALU result.
- MemValid  in  1  load-unit request valid.
- MemReady  out  1  load-unit request accepted this cycle.
- MemReg  in  AW  load destination register.
- MemData  in  WIDTH  load data.
- DrainEn  in  1  when high, the head entry may be written this cycle.
- WriteData  out  WIDTH  to the register file WriteData input.
- WriteRegister  out  AW  to the register file WriteRegister input.
- RegWrite  out  1  to the register file RegWrite input.
- QueryReg1  in  AW  first register queried for a pending write.
- QueryReg2  in  AW  second register queried for a pending write.
- Pending1  out  1  QueryReg1 has a queued write.
- Pending2  out  1  QueryReg2 has a queued write.
- Count  out  $clog2(DEPTH)+1  number of occupied entries.
- Full  out  1  Count == DEPTH.
- Empty  out  1  Count == 0.

Behaviour:
- Reset (async, Reset=1): head pointer, tail pointer and Count go to 0; the PrefMem flag goes to 1.
  - Outputs during reset: Empty=1, Full=0, RegWrite=0, WriteData=0, WriteRegister=0, Pending1=0, Pending2=0.
  - Reset asserted mid-operation discards all queued entries immediately.
- Enqueue: at most one request is accepted per cycle. A request is granted only when !Full; there is no same-cycle pass-through when full, even if a pop also occurs.
  - Only one valid: that source is granted.
  - Both valid: the source named by PrefMem wins (1 = Mem, 0 = Alu). PrefMem toggles on every cycle in which both were valid and a grant occurred.
  - AluReady / MemReady are combinational: the grant AND the source's valid.
  - The losing source keeps its request valid; its inputs must be held stable until its ready is seen.
- Register-0 filter: a granted request with reg == 0 is acknowledged (ready=1) but not stored, and Count does not change.
- Drain: RegWrite = !Empty AND DrainEn. WriteData and WriteRegister show the head entry when !Empty and 0 when Empty.
  - The head is popped on the same Clk edge on which the register file samples RegWrite, so one write completes per cycle. Latency is 1 cycle from acceptance into an empty queue to RegWrite.
- Simultaneous push and pop: Count is unchanged and both pointers advance.
- Pointers are AW-independent, $clog2(DEPTH) bits wide, and wrap modulo DEPTH.
- Pending:
  - PendingN = 1 if any occupied entry, including the head, has reg == QueryRegN and QueryRegN != 0.
  - A request being enqueued in the current cycle is not visible until the next cycle.
  - Purely combinational from stored state.
- Ordering: entries drain strictly in acceptance order. Two writes to the same register both reach the register file, oldest first.

Optional Feature:
- Macro: REGWRITE_QUEUE_BYPASS_EN.
- When defined, adds two outputs:
  - PendingData1  out  WIDTH
  - PendingData2  out  WIDTH
  - Each carries the data of the youngest occupied entry matching QueryRegN, and is 0 when PendingN = 0.
  - Decode uses these to forward operands instead of stalling.
- When undefined, these ports and their matching logic do not exist. All other behaviour is identical.

Decomposition:
- Shared package regfile_pkg holds:
  - REG_AW = 5 and REG_W = 32
  - REG_ZERO = 0
  - the write-request struct (reg, data)
- One sub-module, regwrite_arb: the two-source round-robin arbiter owning PrefMem, producing the grant and select signals. The FIFO storage, pointers and pending-match logic stay in regwrite_queue.

Test Plan:
- Reset, then AluValid=1, AluReg=5, AluData=0xDEADBEEF, DrainEn=1 -> AluReady=1; on the next cycle RegWrite=1, WriteRegister=5, WriteData=0xDEADBEEF; the cycle after that Empty=1. Register file read of register 5 returns 0xDEADBEEF.
- Both sources valid for 4 cycles (Alu regs 1..4, Mem regs 11..14), DrainEn=0 -> grant order Mem, Alu, Mem, Alu; Full=1 after 4 accepts; both ready signals 0 on cycle 5.
- Full queue, DrainEn=1, AluValid=1 -> AluReady=0 on the pop cycle; accepted on the next cycle; Count returns to 4.
- AluReg=0, AluData=0x1234 -> AluReady=1, Count stays 0, RegWrite never asserts; register 0 still reads 0.
- Queue holds regs 7 and 9, QueryReg1=9, QueryReg2=8 -> Pending1=1, Pending2=0. With bypass enabled, writes 9<-0xA then 9<-0xB give PendingData1=0xB.
- Reset asserted with 3 entries queued and RegWrite=1 -> RegWrite=0 and Count=0 immediately, before the next Clk edge.
